// File: rtl/ice40_himax_pwr_pkg.sv
// Shared types and constants for the Himax frame-driven power sequencer.
package ice40_himax_pwr_pkg;

    localparam int unsigned StateW = 3;

    // Clock-enable level that lets a downstream ICG/GB cell pass its clock.
    localparam logic EnOn = 1'b1;

    typedef enum logic [StateW-1:0] {
        StWaitInit  = 3'b000,
        StWaitFrame = 3'b001,
        StWaitVid   = 3'b010,
        StMlRun     = 3'b011,
        StMlDone    = 3'b111,
        StBudget    = 3'b110
    } pwr_state_e;

    function automatic logic is_ml_state(pwr_state_e s);
        return (s == StMlRun) || (s == StMlDone);
    endfunction

endpackage

// File: rtl/ice40_himax_pwr_seq_if.sv
// Handshake and status bundle between the sensor/ML subsystem and the power sequencer.
interface ice40_himax_pwr_seq_if #(
    parameter int unsigned N_ENG  = 1,
    parameter int unsigned CNT_W  = 22,
    parameter int unsigned SKIP_W = 4
);
    logic              i_init_done;
    logic              i_load_done;
    logic              i_cam_vsync;
    logic              i_vid_rdy;
    logic              i_rd_req;
    logic [N_ENG-1:0]  i_ml_rdy;
    logic [SKIP_W-1:0] i_skip;
    logic              i_bypass;
    logic              o_init;
    logic              o_init_en;
    logic              o_vid_en;
    logic [N_ENG-1:0]  o_core_en;
    logic [2:0]        o_state;
    logic              o_timeout;
    logic [CNT_W-1:0]  o_vsync_period;

    modport master (
        output i_init_done, i_load_done, i_cam_vsync, i_vid_rdy, i_rd_req,
        output i_ml_rdy, i_skip, i_bypass,
        input  o_init, o_init_en, o_vid_en, o_core_en, o_state, o_timeout, o_vsync_period
    );

    modport slave (
        input  i_init_done, i_load_done, i_cam_vsync, i_vid_rdy, i_rd_req,
        input  i_ml_rdy, i_skip, i_bypass,
        output o_init, o_init_en, o_vid_en, o_core_en, o_state, o_timeout, o_vsync_period
    );

endinterface

// File: rtl/ice40_himax_vsync_tracker.sv
// VSYNC synchroniser, period measurement, next-frame prediction (pre_video) and
// warm-frame counting for the power sequencer.
module ice40_himax_vsync_tracker #(
    parameter int unsigned CNT_W       = 22,
    parameter int unsigned LEAD        = 2048,
    parameter int unsigned WARM_FRAMES = 3
) (
    input  logic             i_clk,
    input  logic             resetn,
    input  logic             i_cam_vsync,
    input  logic             i_warm_en,
    output logic             o_pre_rise,
    output logic             o_warm_done,
    output logic [CNT_W-1:0] o_period
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LeadC  = CNT_W'(LEAD);

    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] thresh;
    logic             pre_q, pre_d;
    logic             rise_q, rise_d;
    logic [3:0]       warm_q, warm_d;
    logic             vs_edge;

    // sync_q[1:0] is the two-flop synchroniser, sync_q[2] the edge-detect history.
    assign vs_edge = sync_q[1] & ~sync_q[2];
    assign thresh  = (period_q > LeadC) ? (period_q - LeadC) : CNT_W'(1);

    always_comb begin
        sync_d   = {sync_q[1:0], i_cam_vsync};
        cnt_d    = cnt_q;
        period_d = period_q;
        if (vs_edge) begin
            cnt_d    = '0;
            period_d = cnt_q;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        pre_d = pre_q;
        if (cnt_q == thresh) begin
            pre_d = 1'b1;
        end else if (cnt_q == '0) begin
            pre_d = 1'b0;
        end
        rise_d = pre_d & ~pre_q;

        warm_d = warm_q;
        if (!i_warm_en) begin
            warm_d = '0;
        end else if (vs_edge && (warm_q != 4'hF)) begin
            warm_d = warm_q + 4'd1;
        end
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            period_q <= '0;
            pre_q    <= 1'b0;
            rise_q   <= 1'b0;
            warm_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            pre_q    <= pre_d;
            rise_q   <= rise_d;
            warm_q   <= warm_d;
        end
    end

    assign o_pre_rise  = rise_q;
    assign o_warm_done = (warm_q >= 4'(WARM_FRAMES));
    assign o_period    = period_q;

endmodule

// File: rtl/ice40_himax_pwr_seq.sv
// Frame-driven power sequencer: gates init, capture and ML-engine clock domains
// around the predicted camera frame, with skip, watchdog and bypass support.
module ice40_himax_pwr_seq
    import ice40_himax_pwr_pkg::*;
#(
    parameter int unsigned CNT_W       = 22,
    parameter int unsigned LEAD        = 2048,
    parameter int unsigned N_ENG       = 1,
    parameter int unsigned SEQ_MODE    = 0,
    parameter int unsigned WARM_FRAMES = 3,
    parameter int unsigned SKIP_W      = 4,
    parameter int unsigned TMO_W       = 24
) (
    input  logic                 i_clk,
    input  logic                 resetn,
    ice40_himax_pwr_seq_if.slave bus
);

    localparam int unsigned IdxW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam bit          Seq  = (SEQ_MODE != 0);

    pwr_state_e        state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [SKIP_W-1:0] skip_q, skip_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic              vid_rdy_q, rd_req_q;
    logic [N_ENG-1:0]  ml_rdy_q;
    logic              init_q, init_seen_q;
    logic              init_en_q, init_en_d;
    logic              vid_en_q, vid_en_d;
    logic [N_ENG-1:0]  core_en_q, core_en_d;
    logic [N_ENG-1:0]  core_sel;
    logic              pre_rise, warm_done;
    logic              in_ml, wdog_hit, eng_busy, eng_idle, more_eng;
    logic [CNT_W-1:0]  period;

    ice40_himax_vsync_tracker #(
        .CNT_W       (CNT_W),
        .LEAD        (LEAD),
        .WARM_FRAMES (WARM_FRAMES)
    ) u_tracker (
        .i_clk       (i_clk),
        .resetn      (resetn),
        .i_cam_vsync (bus.i_cam_vsync),
        .i_warm_en   (state_q == StWaitFrame),
        .o_pre_rise  (pre_rise),
        .o_warm_done (warm_done),
        .o_period    (period)
    );

    assign in_ml    = is_ml_state(state_q);
    assign wdog_hit = in_ml && (wdog_q == '1);
    assign core_sel = N_ENG'(1) << idx_q;
    assign eng_busy = Seq ? ~ml_rdy_q[idx_q] : |(~ml_rdy_q);
    assign eng_idle = Seq ? ml_rdy_q[idx_q] : &ml_rdy_q;
    assign more_eng = Seq && (int'(idx_q) < int'(N_ENG) - 1);

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StWaitInit;
            idx_q   <= '0;
            skip_q  <= '0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
            wdog_q  <= wdog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        wdog_d  = wdog_q;
        if (in_ml && (wdog_q != '1)) begin
            wdog_d = wdog_q + TMO_W'(1);
        end
        unique case (state_q)
            StWaitInit: begin
                if (bus.i_init_done && bus.i_load_done) state_d = StWaitFrame;
            end
            StWaitFrame: begin
                if (warm_done) state_d = StBudget;
            end
            StBudget: begin
                if (pre_rise) begin
                    if (skip_q == '0) state_d = StWaitVid;
                    else              skip_d  = skip_q - SKIP_W'(1);
                end
            end
            StWaitVid: begin
                wdog_d = '0;
                if (vid_rdy_q) state_d = StMlRun;
            end
            StMlRun: begin
                if (eng_busy) state_d = StMlDone;
            end
            StMlDone: begin
                if (eng_idle) begin
                    if (more_eng) begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = StMlRun;
                    end else begin
                        idx_d   = '0;
                        skip_d  = bus.i_skip;
                        state_d = StBudget;
                    end
                end
            end
            default: state_d = StWaitInit;
        endcase
        // Watchdog expiry abandons the frame regardless of engine progress.
        if (wdog_hit) begin
            idx_d   = '0;
            skip_d  = bus.i_skip;
            state_d = StBudget;
        end
    end

    always_comb begin
        init_en_d = ~(init_seen_q | bus.i_init_done) | bus.i_bypass;
        vid_en_d  = ((state_q != StBudget) ? EnOn : ~EnOn) | bus.i_bypass;
        case (state_q)
            StBudget:          core_en_d = {N_ENG{~EnOn}};
            StWaitVid:         core_en_d = rd_req_q ? {N_ENG{EnOn}} : {N_ENG{~EnOn}};
            StMlRun, StMlDone: core_en_d = Seq ? core_sel : {N_ENG{EnOn}};
            default:           core_en_d = {N_ENG{EnOn}};
        endcase
        core_en_d = core_en_d | {N_ENG{bus.i_bypass}};
    end

    always_ff @(posedge i_clk or negedge resetn) begin
        if (!resetn) begin
            vid_rdy_q   <= 1'b0;
            rd_req_q    <= 1'b0;
            ml_rdy_q    <= '0;
            init_q      <= 1'b0;
            init_seen_q <= 1'b0;
            init_en_q   <= EnOn;
            vid_en_q    <= EnOn;
            core_en_q   <= {N_ENG{EnOn}};
        end else begin
            vid_rdy_q   <= bus.i_vid_rdy;
            rd_req_q    <= bus.i_rd_req;
            ml_rdy_q    <= bus.i_ml_rdy;
            init_q      <= 1'b1;
            init_seen_q <= init_seen_q | bus.i_init_done;
            init_en_q   <= init_en_d;
            vid_en_q    <= vid_en_d;
            core_en_q   <= core_en_d;
        end
    end

    assign bus.o_init         = init_q;
    assign bus.o_init_en      = init_en_q;
    assign bus.o_vid_en       = vid_en_q;
    assign bus.o_core_en      = core_en_q;
    assign bus.o_state        = state_q;
    assign bus.o_timeout      = wdog_hit;
    assign bus.o_vsync_period = period;

endmodule

// File: tb/tb_ice40_himax_pwr_seq.sv
// Randomised frame traffic against a cycle-level reference of the sequencer rules,
// including a mid-run asynchronous reset.
module tb_ice40_himax_pwr_seq;

    localparam int CNT_W  = 16;
    localparam int LEAD   = 64;
    localparam int N_ENG  = 3;
    localparam int WARM   = 3;
    localparam int SKIP_W = 4;
    localparam int TMO_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;
    localparam int WMAX   = (1 << TMO_W) - 1;
    localparam int NCYC   = 16000;
    localparam int MID    = 9000;

    localparam int S_WINIT  = 0;
    localparam int S_WFRAME = 1;
    localparam int S_WVID   = 2;
    localparam int S_MLRUN  = 3;
    localparam int S_MLDONE = 7;
    localparam int S_BUDGET = 6;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;

    ice40_himax_pwr_seq_if #(.N_ENG(N_ENG), .CNT_W(CNT_W), .SKIP_W(SKIP_W)) bus ();

    ice40_himax_pwr_seq #(
        .CNT_W       (CNT_W),
        .LEAD        (LEAD),
        .N_ENG       (N_ENG),
        .SEQ_MODE    (1),
        .WARM_FRAMES (WARM),
        .SKIP_W      (SKIP_W),
        .TMO_W       (TMO_W)
    ) dut (
        .i_clk  (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference state: cycles since the last VSYNC edge, last period, frame phase.
    int         m_state, m_cnt, m_period, m_warm, m_skip, m_idx, m_wd;
    bit         m_pre, m_rise, m_vid_l, m_rd_l, m_seen, m_init;
    bit         m_init_en, m_vid_en;
    logic [2:0] m_ml_l, m_core_en;
    bit   [3:1] vh;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_WINIT; m_cnt = 0; m_period = 0; m_warm = 0; m_skip = 0;
        m_idx = 0; m_wd = 0; m_pre = 0; m_rise = 0; m_vid_l = 0; m_rd_l = 0;
        m_seen = 0; m_init = 0; m_init_en = 1; m_vid_en = 1; m_core_en = 3'b111;
        m_ml_l = 3'b000; vh = 3'b000;
    endtask

    task automatic model_step();
        bit         edge_v, n_pre, in_ml, expire;
        int         thr, n_state, n_idx, n_skip;
        logic [2:0] c;
        edge_v = vh[2] && !vh[3];
        thr    = (m_period > LEAD) ? m_period - LEAD : 1;
        in_ml  = (m_state == S_MLRUN) || (m_state == S_MLDONE);
        expire = in_ml && (m_wd == WMAX);

        n_state = m_state; n_idx = m_idx; n_skip = m_skip;
        case (m_state)
            S_WINIT:  if (bus.i_init_done && bus.i_load_done) n_state = S_WFRAME;
            S_WFRAME: if (m_warm >= WARM) n_state = S_BUDGET;
            S_BUDGET: if (m_rise) begin
                if (m_skip == 0) n_state = S_WVID;
                else n_skip = m_skip - 1;
            end
            S_WVID:   if (m_vid_l) n_state = S_MLRUN;
            S_MLRUN:  if (!m_ml_l[m_idx]) n_state = S_MLDONE;
            S_MLDONE: if (m_ml_l[m_idx]) begin
                if (m_idx < N_ENG - 1) begin
                    n_idx = m_idx + 1; n_state = S_MLRUN;
                end else begin
                    n_idx = 0; n_skip = int'(bus.i_skip); n_state = S_BUDGET;
                end
            end
            default: ;
        endcase
        if (expire) begin
            n_idx = 0; n_skip = int'(bus.i_skip); n_state = S_BUDGET;
        end

        case (m_state)
            S_BUDGET:          c = 3'b000;
            S_WVID:            c = m_rd_l ? 3'b111 : 3'b000;
            S_MLRUN, S_MLDONE: c = 3'b001 << m_idx;
            default:           c = 3'b111;
        endcase
        if (bus.i_bypass) c = 3'b111;
        m_core_en = c;
        m_init_en = !(m_seen || bus.i_init_done) || bus.i_bypass;
        m_vid_en  = (m_state != S_BUDGET) || bus.i_bypass;

        if (m_state == S_WVID) m_wd = 0;
        else if (in_ml && m_wd < WMAX) m_wd = m_wd + 1;
        if (m_state != S_WFRAME) m_warm = 0;
        else if (edge_v && m_warm < 15) m_warm = m_warm + 1;

        n_pre = (m_cnt == thr) ? 1'b1 : ((m_cnt == 0) ? 1'b0 : m_pre);
        m_rise = n_pre && !m_pre;
        m_pre  = n_pre;
        if (edge_v) begin
            m_period = m_cnt; m_cnt = 0;
        end else if (m_cnt < CMAX) begin
            m_cnt = m_cnt + 1;
        end

        m_state = n_state; m_idx = n_idx; m_skip = n_skip;
        m_seen  = m_seen || bus.i_init_done;
        m_init  = 1;
        m_vid_l = bus.i_vid_rdy; m_rd_l = bus.i_rd_req; m_ml_l = bus.i_ml_rdy;
        vh = {vh[2:1], bus.i_cam_vsync};
    endtask

    task automatic compare_all();
        bit exp_tmo;
        exp_tmo = ((m_state == S_MLRUN) || (m_state == S_MLDONE)) && (m_wd == WMAX);
        check_eq("o_state", 32'(bus.o_state), 32'(m_state));
        check_eq("o_init", 32'(bus.o_init), 32'(m_init));
        check_eq("o_init_en", 32'(bus.o_init_en), 32'(m_init_en));
        check_eq("o_vid_en", 32'(bus.o_vid_en), 32'(m_vid_en));
        check_eq("o_core_en", 32'(bus.o_core_en), 32'(m_core_en));
        check_eq("o_timeout", 32'(bus.o_timeout), 32'(exp_tmo));
        check_eq("o_vsync_period", 32'(bus.o_vsync_period), 32'(m_period));
    endtask

    initial begin
        int vs_left, vs_per;
        vs_left = 0; vs_per = 100;
        bus.i_init_done = 0; bus.i_load_done = 0; bus.i_cam_vsync = 0;
        bus.i_vid_rdy = 0; bus.i_rd_req = 0; bus.i_ml_rdy = 3'b111;
        bus.i_skip = 0; bus.i_bypass = 0;
        model_reset();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare_all();
            if (cyc == 3 || cyc == MID + 3) resetn = 1'b1;

            // Camera frames with a 4-cycle VSYNC pulse and a fresh random period each frame.
            if (vs_left == 0) begin
                vs_per  = $urandom_range(300, 40);
                vs_left = vs_per;
            end
            bus.i_cam_vsync = (vs_left > vs_per - 4);
            vs_left--;

            bus.i_load_done = (cyc >= 10);
            bus.i_init_done = (cyc >= 10) && ($urandom_range(19) != 0);
            bus.i_vid_rdy   = ($urandom_range(3) == 0);
            bus.i_rd_req    = $urandom_range(1);
            bus.i_skip      = SKIP_W'($urandom_range(3));
            if ($urandom_range(59) == 0) bus.i_bypass = ~bus.i_bypass;
            for (int e = 0; e < N_ENG; e++) begin
                if ($urandom_range(11) == 0) bus.i_ml_rdy[e] = ~bus.i_ml_rdy[e];
            end
            // Periodic stuck-busy windows drive the watchdog to expiry.
            if ((cyc % 3000) >= 1500 && (cyc % 3000) < 1900) bus.i_ml_rdy = 3'b000;

            if (cyc == MID) begin
                #2 resetn = 1'b0;
                #1 model_reset();
                compare_all();
            end

            @(posedge clk);
            if (resetn) model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
